// File: rtl/wddl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wddl_pkg
//  Description : Shared types and per-rail-pair helpers for the WDDL receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package wddl_pkg;

    typedef enum logic [0:0] {
        PRE  = 1'b0,
        EVAL = 1'b1
    } state_e;

    // Level both rails of a pair sit at during precharge.
    localparam logic WDDL_SPACER = 1'b0;

    function automatic logic rail_spacer_ok(input logic t, input logic f);
        return (t == WDDL_SPACER) && (f == WDDL_SPACER);
    endfunction

    function automatic logic rail_pair_ok(input logic t, input logic f);
        return t ^ f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wddl_dr_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : wddl_dr_receiver_if
//  Description : Dual-rail cone connection plus single-rail valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
interface wddl_dr_receiver_if #(
    parameter int WIDTH = 8
);
    import wddl_pkg::*;

    logic [WIDTH-1:0] t_i;
    logic [WIDTH-1:0] f_i;
    logic             prechrg_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;

    // master: the receiver, which drives precharge and the output word.
    modport master (
        input  t_i, f_i, ready_i,
        output prechrg_o, data_o, valid_o
    );

    modport slave (
        output t_i, f_i, ready_i,
        input  prechrg_o, data_o, valid_o
    );

endinterface
`default_nettype wire

// File: rtl/wddl_rail_check.sv
`default_nettype none
// ============================================================================
//  Module      : wddl_rail_check
//  Description : Per-pair spacer and complementarity violation vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module wddl_rail_check
    import wddl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] t_i,
    input  wire logic [WIDTH-1:0] f_i,
    output logic [WIDTH-1:0]      spacer_bad_vec_o,
    output logic [WIDTH-1:0]      pair_bad_vec_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign spacer_bad_vec_o[i] = !rail_spacer_ok(t_i[i], f_i[i]);
        assign pair_bad_vec_o[i]   = !rail_pair_ok(t_i[i], f_i[i]);
    end

endmodule
`default_nettype wire

// File: rtl/wddl_dr_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : wddl_dr_receiver
//  Description : WDDL cone receiver: precharge sequencing, rail checks and
//                dual-rail to single-rail capture onto a valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
module wddl_dr_receiver
    import wddl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_i,
    input  wire logic          en_i,
    wddl_dr_receiver_if.master bus,
    output logic               pre_err_o,
    output logic               eval_err_o,
    output logic [WIDTH-1:0]   err_mask_o,
    output logic               busy_o
);

    localparam int c_MAX_CYCLES = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int c_CW         = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CW-1:0] c_PRE_LAST  = c_CW'(PRE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_EVAL_LAST = c_CW'(EVAL_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    state_e           state_q, state_d;
    logic [c_CW-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pre_err_q, pre_err_d;
    logic             eval_err_q, eval_err_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    logic [WIDTH-1:0] w_spacer_bad;
    logic [WIDTH-1:0] w_pair_bad;
    logic             w_slot_free;

    wddl_rail_check #(
        .WIDTH (WIDTH)
    ) u_rail_check (
        .t_i              (bus.t_i),
        .f_i              (bus.f_i),
        .spacer_bad_vec_o (w_spacer_bad),
        .pair_bad_vec_o   (w_pair_bad)
    );

    // The output slot is free, or is being emptied on this very edge.
    assign w_slot_free = !valid_q || bus.ready_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q && !bus.ready_i;
        data_d     = data_q;
        pre_err_d  = 1'b0;
        eval_err_d = 1'b0;
        mask_d     = mask_q;

        unique case (state_q)
            PRE: begin
                if (cnt_q == c_PRE_LAST) begin
                    if (|w_spacer_bad) begin
                        pre_err_d = 1'b1;
                        mask_d    = w_spacer_bad;
                    end
                    if (en_i && w_slot_free) begin
                        state_d = EVAL;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            EVAL: begin
                if (cnt_q == c_EVAL_LAST) begin
                    if (w_pair_bad == '0) begin
                        data_d  = bus.t_i;
                        valid_d = 1'b1;
                    end else begin
                        eval_err_d = 1'b1;
                        mask_d     = w_pair_bad;
                    end
                    state_d = PRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = PRE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= PRE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            pre_err_q  <= 1'b0;
            eval_err_q <= 1'b0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            pre_err_q  <= pre_err_d;
            eval_err_q <= eval_err_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.prechrg_o = (state_q == PRE);
    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign busy_o        = (state_q == EVAL);
    assign pre_err_o     = pre_err_q;
    assign eval_err_o    = eval_err_q;
    assign err_mask_o    = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_wddl_dr_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wddl_dr_receiver
//  Description : Self-checking bench for wddl_dr_receiver (1/1 and 2/3 timing).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wddl_dr_receiver;

    typedef struct {
        int         w;      // position within the wave; w < P means precharge
        logic       v;
        logic [7:0] d;
        logic       pe;
        logic       ee;
        logic [7:0] m;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic rdy = 1'b1;
    logic [7:0] pre_t = 8'h00, pre_f = 8'h00;
    logic [7:0] ev_t  = 8'hA5, ev_f  = 8'h5A;
    logic [7:0] b_pre0 = 8'h00, b_pre1 = 8'h00;
    logic chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    logic       pe_a, ee_a, busy_a, pe_b, ee_b, busy_b;
    logic [7:0] mask_a, mask_b;
    mdl_t       m_a, m_b;

    always #5 clk = ~clk;

    wddl_dr_receiver_if #(.WIDTH(8)) bus_a ();
    wddl_dr_receiver_if #(.WIDTH(8)) bus_b ();

    // Cone models: rails follow the precharge signal they are given.
    assign bus_a.t_i     = bus_a.prechrg_o ? pre_t : ev_t;
    assign bus_a.f_i     = bus_a.prechrg_o ? pre_f : ev_f;
    assign bus_a.ready_i = rdy;
    assign bus_b.t_i     = bus_b.prechrg_o ? ((m_b.w == 0) ? b_pre0 : b_pre1) : 8'hA5;
    assign bus_b.f_i     = bus_b.prechrg_o ? 8'h00 : 8'h5A;
    assign bus_b.ready_i = 1'b1;

    wddl_dr_receiver #(.WIDTH(8), .PRE_CYCLES(1), .EVAL_CYCLES(1)) dut_a (
        .clk        (clk),
        .rst_i      (rst),
        .en_i       (en),
        .bus        (bus_a),
        .pre_err_o  (pe_a),
        .eval_err_o (ee_a),
        .err_mask_o (mask_a),
        .busy_o     (busy_a)
    );

    wddl_dr_receiver #(.WIDTH(8), .PRE_CYCLES(2), .EVAL_CYCLES(3)) dut_b (
        .clk        (clk),
        .rst_i      (rst),
        .en_i       (1'b1),
        .bus        (bus_b),
        .pre_err_o  (pe_b),
        .eval_err_o (ee_b),
        .err_mask_o (mask_b),
        .busy_o     (busy_b)
    );

    function automatic mdl_t step(input mdl_t s, input int P, input int E,
                                  input logic r, input logic e, input logic rd,
                                  input logic [7:0] t, input logic [7:0] f);
        mdl_t n;
        bit   cap;
        n   = s;
        cap = 1'b0;
        if (r) begin
            n.w = 0; n.v = 1'b0; n.d = 8'h00; n.pe = 1'b0; n.ee = 1'b0; n.m = 8'h00;
            return n;
        end
        n.pe = 1'b0;
        n.ee = 1'b0;
        if (s.w < P) begin
            if (s.w == P - 1) begin
                if ((t | f) != 8'h00) begin
                    n.pe = 1'b1;
                    n.m  = t | f;
                end
                if (e && (!s.v || rd)) n.w = P;
            end else begin
                n.w = s.w + 1;
            end
        end else if (s.w == P + E - 1) begin
            if ((t ^ f) == 8'hFF) begin
                cap = 1'b1;
                n.d = t;
            end else begin
                n.ee = 1'b1;
                n.m  = ~(t ^ f);
            end
            n.w = 0;
        end else begin
            n.w = s.w + 1;
        end
        n.v = cap ? 1'b1 : (s.v && !rd);
        return n;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_a <= step(m_a, 1, 1, rst, en, rdy, bus_a.t_i, bus_a.f_i);
        m_b <= step(m_b, 2, 3, rst, 1'b1, 1'b1, bus_b.t_i, bus_b.f_i);
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            cmp("A.prechrg", 32'(bus_a.prechrg_o), 32'(m_a.w < 1));
            cmp("A.busy",    32'(busy_a),          32'(m_a.w >= 1));
            cmp("A.valid",   32'(bus_a.valid_o),   32'(m_a.v));
            cmp("A.data",    32'(bus_a.data_o),    32'(m_a.d));
            cmp("A.pre_err", 32'(pe_a),            32'(m_a.pe));
            cmp("A.eval_err",32'(ee_a),            32'(m_a.ee));
            cmp("A.mask",    32'(mask_a),          32'(m_a.m));
            cmp("B.prechrg", 32'(bus_b.prechrg_o), 32'(m_b.w < 2));
            cmp("B.busy",    32'(busy_b),          32'(m_b.w >= 2));
            cmp("B.valid",   32'(bus_b.valid_o),   32'(m_b.v));
            cmp("B.data",    32'(bus_b.data_o),    32'(m_b.d));
            cmp("B.pre_err", 32'(pe_b),            32'(m_b.pe));
            cmp("B.eval_err",32'(ee_b),            32'(m_b.ee));
            cmp("B.mask",    32'(mask_b),          32'(m_b.m));
        end
    end

    // Bounded wait for an event: 0 A.valid, 1 A.eval_err, 2 A.pre_err, 3 A.valid with 3C, 4 B.pre_err
    task automatic wait_ev(input int which, input int max, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #1;
            case (which)
                0: ok = bus_a.valid_o;
                1: ok = ee_a;
                2: ok = pe_a;
                3: ok = bus_a.valid_o && (bus_a.data_o == 8'h3C);
                4: ok = pe_b;
                default: ok = 1'b0;
            endcase
            if (ok) break;
        end
        cmp(nm, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [3:0] seq_p, seq_v;
        logic [9:0] seq_pb, seq_vb;
        int         perr_cnt;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        cmp("rst.prechrg", 32'(bus_a.prechrg_o), 32'd1);
        cmp("rst.valid",   32'(bus_a.valid_o),   32'd0);
        cmp("rst.data",    32'(bus_a.data_o),    32'h00);
        cmp("rst.mask",    32'(mask_a),          32'h00);
        cmp("rst.busy",    32'(busy_a),          32'd0);

        // Back-to-back waves, one word every two cycles
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        seq_p = '0;
        seq_v = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seq_p = {seq_p[2:0], bus_a.prechrg_o};
            seq_v = {seq_v[2:0], bus_a.valid_o};
        end
        cmp("t1.prechrg_seq", 32'(seq_p), 32'h5);
        cmp("t1.valid_seq",   32'(seq_v), 32'h5);
        cmp("t1.data",        32'(bus_a.data_o), 32'hA5);

        // Non-complementary pair at bit 0
        @(negedge clk);
        ev_f = 8'h5B;
        wait_ev(1, 8, "t2.eval_err_wait");
        cmp("t2.mask",  32'(mask_a),        32'h01);
        cmp("t2.valid", 32'(bus_a.valid_o), 32'd0);
        @(negedge clk);
        ev_f = 8'h5A;
        wait_ev(0, 8, "t2.recover_wait");
        cmp("t2.recover_data", 32'(bus_a.data_o), 32'hA5);

        // Rail stuck high in precharge
        @(negedge clk);
        pre_t = 8'h10;
        wait_ev(2, 8, "t3.pre_err_wait");
        cmp("t3.mask", 32'(mask_a), 32'h10);
        @(negedge clk);
        pre_t = 8'h00;

        // Back-pressure holds the captured word and precharge
        ev_t = 8'h3C;
        ev_f = 8'hC3;
        wait_ev(3, 10, "t4.capture_wait");
        @(negedge clk);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            cmp("t4.hold_prechrg", 32'(bus_a.prechrg_o), 32'd1);
            cmp("t4.hold_busy",    32'(busy_a),          32'd0);
            cmp("t4.hold_data",    32'(bus_a.data_o),    32'h3C);
            cmp("t4.hold_valid",   32'(bus_a.valid_o),   32'd1);
        end
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        cmp("t4.release_valid",   32'(bus_a.valid_o),   32'd0);
        cmp("t4.release_prechrg", 32'(bus_a.prechrg_o), 32'd0);

        // Reset lands during EVAL: the wave is discarded
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cmp("t5.prechrg", 32'(bus_a.prechrg_o), 32'd1);
        cmp("t5.valid",   32'(bus_a.valid_o),   32'd0);
        cmp("t5.data",    32'(bus_a.data_o),    32'h00);
        cmp("t5.mask",    32'(mask_a),          32'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // PRE_CYCLES=2, EVAL_CYCLES=3; junk on the first PRE cycle is not checked
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cmp("t6.rst_prechrg", 32'(bus_b.prechrg_o), 32'd1);
        @(negedge clk);
        rst    = 1'b0;
        b_pre0 = 8'h40;
        seq_pb   = '0;
        seq_vb   = '0;
        perr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            seq_pb = {seq_pb[8:0], bus_b.prechrg_o};
            seq_vb = {seq_vb[8:0], bus_b.valid_o};
            if (pe_b) perr_cnt++;
        end
        cmp("t6.prechrg_seq", 32'(seq_pb), 32'(10'b1000110001));
        cmp("t6.valid_seq",   32'(seq_vb), 32'(10'b0000100001));
        cmp("t6.no_pre_err",  32'(perr_cnt), 32'd0);
        @(negedge clk);
        b_pre0 = 8'h00;
        b_pre1 = 8'h40;
        wait_ev(4, 12, "t6.pre_err_wait");
        cmp("t6.mask", 32'(mask_b), 32'h40);
        @(negedge clk);
        b_pre1 = 8'h00;
        repeat (3) @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wddl_dr_receiver.md
Name: wddl_dr_receiver

Overview:
- Receiving end of a WDDL (wave dynamic differential logic) dual-rail cone.
- Generates the precharge phase signal that drives the cone.
- Checks the spacer in precharge (all rails low) and complementarity in evaluation (exactly one rail high per bit).
- Converts the evaluated dual-rail word to single-rail data, delivered over a valid/ready handshake.

Parameters:
- WIDTH, 8, number of dual-rail bit pairs.
- PRE_CYCLES, 1, clock cycles per precharge phase; must be >= 1.
- EVAL_CYCLES, 1, clock cycles per evaluation phase; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  permits starting a new evaluation wave.
- t_i  in  WIDTH  true rails from the WDDL cone.
- f_i  in  WIDTH  false rails from the WDDL cone.
- prechrg_o  out  1  1 = precharge phase (rails must be 0); 0 = evaluate.
- data_o  out  WIDTH  single-rail captured word.
- valid_o  out  1  data_o holds an unconsumed word.
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i.
- pre_err_o  out  1  one-cycle pulse: a rail was high during a checked precharge cycle.
- eval_err_o  out  1  one-cycle pulse: a non-complementary pair at end of evaluation.
- err_mask_o  out  WIDTH  offending bit positions of the most recent error; held until the next error.
- busy_o  out  1  high while in EVAL.

Behaviour:
- Reset values:
  - state PRE, phase counter 0.
  - prechrg_o=1, valid_o=0, data_o=0.
  - pre_err_o=0, eval_err_o=0, err_mask_o=0, busy_o=0.
- State PRE:
  - prechrg_o=1; counter increments to PRE_CYCLES-1, then saturates.
  - On every cycle with counter == PRE_CYCLES-1, check rails: if |(t_i|f_i), then pre_err_o=1 next cycle and err_mask_o<=t_i|f_i.
  - Transition to EVAL (counter reset to 0) on a cycle with counter == PRE_CYCLES-1 && en_i && (!valid_o || ready_i). Otherwise remain in PRE (wait, precharge held).
- State EVAL:
  - prechrg_o=0, busy_o=1; counter runs 0..EVAL_CYCLES-1.
  - On the last cycle, sample t_i/f_i:
    - All pairs valid, i.e. &(t_i^f_i): data_o<=t_i and valid_o<=1 next cycle.
    - Otherwise: eval_err_o=1 next cycle, err_mask_o<=~(t_i^f_i), valid_o unchanged, no capture.
  - Always return to PRE with counter 0.
  - en_i deasserting mid-EVAL does not abort the wave.
- Handshake:
  - valid_o falls the cycle after valid_o && ready_i.
  - data_o is stable while valid_o=1 && !ready_i.
  - EVAL is entered only when the slot is free or being freed, so capture never coincides with a held word. No overflow path exists.
- Throughput and latency:
  - Wave period is PRE_CYCLES+EVAL_CYCLES cycles with en_i=1 and ready_i=1.
  - valid_o rises 1 cycle after the last EVAL cycle.
- Simultaneous errors: if pre and eval errors would both update err_mask_o in the same cycle (they cannot), eval has priority. Only one check occurs per cycle by construction.
- Reset mid-operation: rst_i in any state, including mid-EVAL, takes effect next edge. The wave is discarded and all outputs take their reset values.
- Counter width: $clog2(max(PRE_CYCLES,EVAL_CYCLES)+1).

Decomposition:
- Package wddl_pkg holds:
  - state enum {PRE, EVAL}.
  - constant WDDL_SPACER = 1'b0 (precharge rail level).
  - functions rail_spacer_ok(t,f) and rail_pair_ok(t,f).
- Sub-module wddl_rail_check (combinational, parameter WIDTH) outputs spacer_bad_vec = t|f and pair_bad_vec = ~(t^f). The FSM/register top instantiates it once.

Test Plan:
1. Defaults, reset then en_i=1, ready_i=1, cone drives t_i=8'hA5, f_i=8'h5A in EVAL and 0 in PRE -> prechrg_o toggles 1,0,1,0; valid_o pulses every 2 cycles with data_o=8'hA5; no errors.
2. EVAL with t_i=8'hA5, f_i=8'h5B -> eval_err_o single pulse, err_mask_o=8'h01, valid_o stays 0; next wave with correct rails captures normally.
3. PRE with t_i=8'h10, f_i=0 -> pre_err_o pulse, err_mask_o=8'h10; EVAL still entered on schedule.
4. Capture 8'h3C, then hold ready_i=0 for 5 cycles -> prechrg_o stays 1, busy_o=0, data_o=8'h3C stable. Raise ready_i -> valid_o drops next cycle and EVAL starts the same edge.
5. Assert rst_i during an EVAL cycle -> next cycle prechrg_o=1, valid_o=0, err_mask_o=0, and no capture of that wave.
6. PRE_CYCLES=2, EVAL_CYCLES=3 -> prechrg_o pattern 1,1,0,0,0 repeating; valid_o once per 5 cycles; spacer checked only on the 2nd PRE cycle.
